jam_cost_arbiter: RTL and testbench

// - Shares the single JAM cost-ROM lookup port (W,J -> Cost) between NUM_REQ permutation engines.
// - Round-robin grant, held for one burst (one permutation = up to MAX_BURST lookups).
// - Routes each ROM result back to the engine that issued the lookup.
// - Sits between the engines and the testbench/ROM Cost interface.

---
 rtl/jam_cost_arbiter_pkg.sv | 15 +
 rtl/jam_cost_arbiter_if.sv | 31 +++
 rtl/jam_cost_arbiter_rr_pick.sv | 30 +++
 rtl/jam_cost_arbiter.sv | 144 ++++++++++++++
 tb/tb_jam_cost_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jam_cost_arbiter_pkg.sv
// Shared constants and state encoding for the JAM cost-ROM arbiter.
package jam_cost_arbiter_pkg;

  localparam int DEF_NUM_REQ   = 2;
  localparam int DEF_IDX_W     = 3;
  localparam int DEF_COST_W    = 7;
  localparam int DEF_ROM_LAT   = 1;
  localparam int DEF_MAX_BURST = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

endpackage

// File: rtl/jam_cost_arbiter_if.sv
// Engine-side request/response bus plus the cost-ROM lookup port.
interface jam_cost_arbiter_if import jam_cost_arbiter_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = DEF_IDX_W,
  parameter int COST_W  = DEF_COST_W
);

  logic [NUM_REQ-1:0]       REQ;
  logic [NUM_REQ-1:0]       LAST;
  logic [NUM_REQ*IDX_W-1:0] REQ_W;
  logic [NUM_REQ*IDX_W-1:0] REQ_J;
  logic [NUM_REQ-1:0]       GNT;
  logic [IDX_W-1:0]         W;
  logic [IDX_W-1:0]         J;
  logic [COST_W-1:0]        Cost;
  logic [NUM_REQ-1:0]       RSP_VALID;
  logic [COST_W-1:0]        RSP_COST;
  logic                     BUSY;

  // master = engines and ROM together, slave = the arbiter
  modport master (
    output REQ, LAST, REQ_W, REQ_J, Cost,
    input  GNT, W, J, RSP_VALID, RSP_COST, BUSY
  );

  modport slave (
    input  REQ, LAST, REQ_W, REQ_J, Cost,
    output GNT, W, J, RSP_VALID, RSP_COST, BUSY
  );

endinterface

// File: rtl/jam_cost_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr.
module jam_cost_arbiter_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int PW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [PW-1:0]      idx,
  output logic               any
);

  always_comb begin
    int c;
    c      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = int'(ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!any && req[c]) begin
        any = 1'b1;
        idx = PW'(c);
      end
    end
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/jam_cost_arbiter.sv
// Round-robin sharing of one cost-ROM lookup port among NUM_REQ engines,
// with per-burst grants and an in-order response return path.
module jam_cost_arbiter import jam_cost_arbiter_pkg::*; #(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int IDX_W     = DEF_IDX_W,
  parameter int COST_W    = DEF_COST_W,
  parameter int ROM_LAT   = DEF_ROM_LAT,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input logic              CLK,
  input logic              RST_N,
  jam_cost_arbiter_if.slave bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST_CNT = BW'(MAX_BURST - 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

  state_t             state, state_nxt;
  logic [PW-1:0]      ptr, ptr_nxt;
  logic [PW-1:0]      owner, owner_nxt;
  logic [NUM_REQ-1:0] owner_oh, owner_oh_nxt;
  logic [BW-1:0]      beat_cnt, beat_cnt_nxt;

  logic [NUM_REQ-1:0] pick_oh;
  logic [PW-1:0]      pick_idx;
  logic               pick_any;

  logic               beat;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   w_out, j_out;

  logic [ROM_LAT-1:0]         pipe_vld;
  logic [ROM_LAT-1:0][PW-1:0] pipe_own;
  logic                       tap_vld;
  logic [PW-1:0]              tap_own;
  logic [COST_W-1:0]          cost_q;
  logic [NUM_REQ-1:0]         rsp_valid;

  jam_cost_arbiter_rr_pick #(
    .NUM_REQ(NUM_REQ),
    .PW     (PW)
  ) u_rr_pick (
    .req   (bus.REQ),
    .ptr   (ptr),
    .onehot(pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      owner    <= '0;
      owner_oh <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      owner    <= owner_nxt;
      owner_oh <= owner_oh_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    owner_nxt    = owner;
    owner_oh_nxt = owner_oh;
    beat_cnt_nxt = beat_cnt;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_nxt    = ST_BURST;
          owner_nxt    = pick_idx;
          owner_oh_nxt = pick_oh;
          beat_cnt_nxt = '0;
        end
      end
      ST_BURST: begin
        // a stalled owner keeps the grant indefinitely; only beats advance
        if (beat) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
          if (bus.LAST[owner] || (beat_cnt == LAST_CNT)) begin
            state_nxt = ST_IDLE;
            ptr_nxt   = (owner == LAST_IDX) ? '0 : owner + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt   = '0;
    beat  = 1'b0;
    w_out = '0;
    j_out = '0;
    if (state == ST_BURST) begin
      gnt  = owner_oh;
      beat = bus.REQ[owner];
      if (beat) begin
        w_out = bus.REQ_W[int'(owner)*IDX_W +: IDX_W];
        j_out = bus.REQ_J[int'(owner)*IDX_W +: IDX_W];
      end
    end
  end

  // {valid, owner} travels alongside the ROM access so results return in issue order
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pipe_vld <= '0;
      pipe_own <= '0;
      cost_q   <= '0;
    end else begin
      pipe_vld[0] <= beat;
      pipe_own[0] <= owner;
      for (int k = 1; k < ROM_LAT; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_own[k] <= pipe_own[k-1];
      end
      if (tap_vld) cost_q <= bus.Cost;
    end
  end

  assign tap_vld = pipe_vld[ROM_LAT-1];
  assign tap_own = pipe_own[ROM_LAT-1];

  always_comb begin
    rsp_valid = '0;
    if (tap_vld) rsp_valid[tap_own] = 1'b1;
  end

  assign bus.GNT       = gnt;
  assign bus.W         = w_out;
  assign bus.J         = j_out;
  assign bus.RSP_VALID = rsp_valid;
  assign bus.RSP_COST  = tap_vld ? bus.Cost : cost_q;
  assign bus.BUSY      = (state == ST_BURST) | (|pipe_vld);

endmodule

// File: tb/tb_jam_cost_arbiter.sv
// Directed bench for jam_cost_arbiter: a 2-engine and a 3-engine instance with a registered cost ROM model.
module tb_jam_cost_arbiter;

  logic CLK;
  logic rst_n2, rst_n3;
  int   n_tests;
  int   n_fail;

  jam_cost_arbiter_if #(.NUM_REQ(2), .IDX_W(3), .COST_W(7)) b2 ();
  jam_cost_arbiter_if #(.NUM_REQ(3), .IDX_W(3), .COST_W(7)) b3 ();

  jam_cost_arbiter #(.NUM_REQ(2), .IDX_W(3), .COST_W(7), .ROM_LAT(1), .MAX_BURST(8)) dut2 (
    .CLK(CLK), .RST_N(rst_n2), .bus(b2.slave));

  jam_cost_arbiter #(.NUM_REQ(3), .IDX_W(3), .COST_W(7), .ROM_LAT(1), .MAX_BURST(8)) dut3 (
    .CLK(CLK), .RST_N(rst_n3), .bus(b3.slave));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [6:0] rom(input logic [2:0] w, input logic [2:0] j);
    rom = 7'(int'(w) * 13 + int'(j) * 7 + 5);
  endfunction

  // one-cycle-latency cost ROM
  always @(posedge CLK) begin
    b2.Cost <= rom(b2.W, b2.J);
    b3.Cost <= rom(b3.W, b3.J);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle2();
    b2.REQ = '0; b2.LAST = '0; b2.REQ_W = '0; b2.REQ_J = '0;
  endtask

  task automatic reset2();
    idle2();
    rst_n2 = 1'b0;
    tick();
    rst_n2 = 1'b1;
  endtask

  task automatic test_reset();
    idle2();
    b3.REQ = '0; b3.LAST = '0; b3.REQ_W = '0; b3.REQ_J = '0;
    rst_n2 = 1'b0; rst_n3 = 1'b0;
    tick(); tick();
    n_tests++;
    if ({b2.GNT, b2.RSP_VALID, b2.RSP_COST, b2.BUSY} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset2: gnt=%b rsp_valid=%b rsp_cost=%h busy=%b, need all 0", b2.GNT, b2.RSP_VALID, b2.RSP_COST, b2.BUSY);
    end
    n_tests++;
    if ({b3.GNT, b3.RSP_VALID, b3.RSP_COST, b3.BUSY} !== 14'h0000) begin
      n_fail++;
      $display("FAIL reset3: gnt=%b rsp_valid=%b rsp_cost=%h busy=%b, need all 0", b3.GNT, b3.RSP_VALID, b3.RSP_COST, b3.BUSY);
    end
    rst_n2 = 1'b1; rst_n3 = 1'b1;
    tick();
  endtask

  task automatic test_single();
    reset2();
    b2.REQ = 2'b01;
    #1;
    n_tests++;
    if (b2.GNT !== 2'b00) begin n_fail++; $display("FAIL single_idle_gnt: got %b need 00", b2.GNT); end
    tick();
    for (int i = 0; i < 8; i++) begin
      b2.REQ_W = {3'd0, 3'(i)};
      b2.REQ_J = {3'd0, 3'(7 - i)};
      b2.LAST  = (i == 7) ? 2'b01 : 2'b00;
      #1;
      n_tests++;
      if (b2.GNT !== 2'b01 || b2.W !== 3'(i) || b2.J !== 3'(7 - i)) begin
        n_fail++;
        $display("FAIL single_beat%0d: gnt=%b w=%0d j=%0d need 01 %0d %0d", i, b2.GNT, b2.W, b2.J, i, 7 - i);
      end
      if (i > 0) begin
        n_tests++;
        if (b2.RSP_VALID !== 2'b01 || b2.RSP_COST !== rom(3'(i - 1), 3'(8 - i))) begin
          n_fail++;
          $display("FAIL single_rsp%0d: valid=%b cost=%h need 01 %h", i - 1, b2.RSP_VALID, b2.RSP_COST, rom(3'(i - 1), 3'(8 - i)));
        end
      end else begin
        n_tests++;
        if (b2.RSP_VALID !== 2'b00) begin n_fail++; $display("FAIL single_rsp_early: got %b need 00", b2.RSP_VALID); end
      end
      tick();
    end
    idle2();
    #1;
    n_tests++;
    if (b2.RSP_VALID !== 2'b01 || b2.RSP_COST !== rom(3'd7, 3'd0) || b2.GNT !== 2'b00 || b2.BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL single_rsp7: valid=%b cost=%h gnt=%b busy=%b need 01 %h 00 1", b2.RSP_VALID, b2.RSP_COST, b2.GNT, b2.BUSY, rom(3'd7, 3'd0));
    end
    tick();
    n_tests++;
    if (b2.RSP_VALID !== 2'b00 || b2.BUSY !== 1'b0 || b2.RSP_COST !== rom(3'd7, 3'd0)) begin
      n_fail++;
      $display("FAIL single_drain: valid=%b busy=%b cost=%h need 00 0 %h", b2.RSP_VALID, b2.BUSY, b2.RSP_COST, rom(3'd7, 3'd0));
    end
  endtask

  task automatic test_both();
    reset2();
    b2.REQ = 2'b11; b2.LAST = 2'b11;
    b2.REQ_W = {3'd3, 3'd1}; b2.REQ_J = {3'd4, 3'd2};
    #1;
    n_tests++;
    if (b2.GNT !== 2'b00) begin n_fail++; $display("FAIL both_idle: got %b need 00", b2.GNT); end
    tick();
    n_tests++;
    if (b2.GNT !== 2'b01 || b2.W !== 3'd1 || b2.J !== 3'd2) begin
      n_fail++; $display("FAIL both_g0: gnt=%b w=%0d j=%0d need 01 1 2", b2.GNT, b2.W, b2.J);
    end
    tick();
    n_tests++;
    if (b2.GNT !== 2'b00 || b2.RSP_VALID !== 2'b01 || b2.RSP_COST !== rom(3'd1, 3'd2)) begin
      n_fail++; $display("FAIL both_gap0: gnt=%b valid=%b cost=%h need 00 01 %h", b2.GNT, b2.RSP_VALID, b2.RSP_COST, rom(3'd1, 3'd2));
    end
    tick();
    n_tests++;
    if (b2.GNT !== 2'b10 || b2.W !== 3'd3 || b2.J !== 3'd4) begin
      n_fail++; $display("FAIL both_g1: gnt=%b w=%0d j=%0d need 10 3 4", b2.GNT, b2.W, b2.J);
    end
    tick();
    n_tests++;
    if (b2.GNT !== 2'b00 || b2.RSP_VALID !== 2'b10 || b2.RSP_COST !== rom(3'd3, 3'd4)) begin
      n_fail++; $display("FAIL both_gap1: gnt=%b valid=%b cost=%h need 00 10 %h", b2.GNT, b2.RSP_VALID, b2.RSP_COST, rom(3'd3, 3'd4));
    end
    tick();
    n_tests++;
    if (b2.GNT !== 2'b01) begin n_fail++; $display("FAIL both_g0_again: got %b need 01", b2.GNT); end
    tick();
    idle2();
    tick(); tick();
  endtask

  task automatic test_stall();
    reset2();
    b2.REQ = 2'b01;
    tick();
    b2.REQ_W = {3'd0, 3'd2}; b2.REQ_J = {3'd0, 3'd5};
    #1;
    n_tests++;
    if (b2.GNT !== 2'b01 || b2.W !== 3'd2) begin n_fail++; $display("FAIL stall_b0: gnt=%b w=%0d need 01 2", b2.GNT, b2.W); end
    tick();
    b2.REQ_W = {3'd0, 3'd4}; b2.REQ_J = {3'd0, 3'd1};
    #1;
    n_tests++;
    if (b2.RSP_VALID !== 2'b01 || b2.RSP_COST !== rom(3'd2, 3'd5)) begin
      n_fail++; $display("FAIL stall_r0: valid=%b cost=%h need 01 %h", b2.RSP_VALID, b2.RSP_COST, rom(3'd2, 3'd5));
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      b2.REQ = 2'b00;
      #1;
      n_tests++;
      if (b2.GNT !== 2'b01 || b2.W !== 3'd0 || b2.J !== 3'd0 || b2.BUSY !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold%0d: gnt=%b w=%0d j=%0d busy=%b need 01 0 0 1", i, b2.GNT, b2.W, b2.J, b2.BUSY);
      end
      n_tests++;
      if (b2.RSP_VALID !== ((i == 0) ? 2'b01 : 2'b00)) begin
        n_fail++; $display("FAIL stall_rsp%0d: got %b need %b", i, b2.RSP_VALID, (i == 0) ? 2'b01 : 2'b00);
      end
      tick();
    end
    b2.REQ = 2'b01; b2.LAST = 2'b01;
    b2.REQ_W = {3'd0, 3'd6}; b2.REQ_J = {3'd0, 3'd6};
    #1;
    n_tests++;
    if (b2.GNT !== 2'b01 || b2.W !== 3'd6) begin n_fail++; $display("FAIL stall_resume: gnt=%b w=%0d need 01 6", b2.GNT, b2.W); end
    tick();
    idle2();
    #1;
    n_tests++;
    if (b2.GNT !== 2'b00 || b2.RSP_VALID !== 2'b01 || b2.RSP_COST !== rom(3'd6, 3'd6)) begin
      n_fail++; $display("FAIL stall_end: gnt=%b valid=%b cost=%h need 00 01 %h", b2.GNT, b2.RSP_VALID, b2.RSP_COST, rom(3'd6, 3'd6));
    end
    tick();
  endtask

  task automatic test_force_release();
    reset2();
    b2.REQ = 2'b10;
    tick();
    for (int i = 0; i < 8; i++) begin
      b2.REQ   = 2'b11;
      b2.REQ_W = {3'(i), 3'd7};
      b2.REQ_J = {3'(i) ^ 3'd5, 3'd7};
      #1;
      n_tests++;
      if (b2.GNT !== 2'b10 || b2.W !== 3'(i)) begin
        n_fail++; $display("FAIL force_beat%0d: gnt=%b w=%0d need 10 %0d", i, b2.GNT, b2.W, i);
      end
      tick();
    end
    #1;
    n_tests++;
    if (b2.GNT !== 2'b00 || b2.RSP_VALID !== 2'b10 || b2.RSP_COST !== rom(3'd7, 3'd2)) begin
      n_fail++; $display("FAIL force_release: gnt=%b valid=%b cost=%h need 00 10 %h", b2.GNT, b2.RSP_VALID, b2.RSP_COST, rom(3'd7, 3'd2));
    end
    tick();
    b2.LAST = 2'b01;
    #1;
    n_tests++;
    if (b2.GNT !== 2'b01 || b2.W !== 3'd7) begin n_fail++; $display("FAIL force_next: gnt=%b w=%0d need 01 7", b2.GNT, b2.W); end
    tick();
    idle2();
    #1;
    n_tests++;
    if (b2.RSP_VALID !== 2'b01) begin n_fail++; $display("FAIL force_next_rsp: got %b need 01", b2.RSP_VALID); end
    tick(); tick();
  endtask

  task automatic test_reset_inflight();
    reset2();
    b2.REQ = 2'b01; b2.LAST = 2'b01;
    b2.REQ_W = {3'd0, 3'd5}; b2.REQ_J = {3'd0, 3'd2};
    tick();
    #1;
    n_tests++;
    if (b2.GNT !== 2'b01) begin n_fail++; $display("FAIL rstfl_gnt: got %b need 01", b2.GNT); end
    rst_n2 = 1'b0;
    b2.REQ = 2'b11; b2.LAST = 2'b11;
    tick();
    n_tests++;
    if (b2.RSP_VALID !== 2'b00 || b2.GNT !== 2'b00 || b2.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL rstfl_clear: valid=%b gnt=%b busy=%b need 00 00 0", b2.RSP_VALID, b2.GNT, b2.BUSY);
    end
    rst_n2 = 1'b1;
    tick();
    n_tests++;
    if (b2.GNT !== 2'b01) begin n_fail++; $display("FAIL rstfl_first_gnt: got %b need 01", b2.GNT); end
    tick();
    idle2();
    tick(); tick();
  endtask

  task automatic test_three();
    logic [2:0] eg [8];
    logic [2:0] er [8];
    int         eo [8];
    eg = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    er = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
    eo = '{0, 0, 0, 0, 1, 0, 2, 0};
    b3.REQ = 3'b111; b3.LAST = 3'b111;
    b3.REQ_W = {3'd3, 3'd2, 3'd1};
    b3.REQ_J = {3'd4, 3'd5, 3'd6};
    for (int i = 0; i < 8; i++) begin
      #1;
      n_tests++;
      if (b3.GNT !== eg[i] || b3.RSP_VALID !== er[i]) begin
        n_fail++; $display("FAIL three_c%0d: gnt=%b valid=%b need %b %b", i, b3.GNT, b3.RSP_VALID, eg[i], er[i]);
      end
      if (er[i] != 3'b000) begin
        n_tests++;
        if (b3.RSP_COST !== rom(3'(eo[i] + 1), 3'(6 - eo[i]))) begin
          n_fail++; $display("FAIL three_cost%0d: got %h need %h", i, b3.RSP_COST, rom(3'(eo[i] + 1), 3'(6 - eo[i])));
        end
      end
      tick();
    end
    b3.REQ = '0; b3.LAST = '0;
    #1;
    n_tests++;
    if (b3.RSP_VALID !== 3'b001 || b3.RSP_COST !== rom(3'd1, 3'd6) || b3.GNT !== 3'b000) begin
      n_fail++; $display("FAIL three_tail: valid=%b cost=%h gnt=%b need 001 %h 000", b3.RSP_VALID, b3.RSP_COST, b3.GNT, rom(3'd1, 3'd6));
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n2  = 1'b0;
    rst_n3  = 1'b0;
    idle2();
    b3.REQ = '0; b3.LAST = '0; b3.REQ_W = '0; b3.REQ_J = '0;
    test_reset();
    test_single();
    test_both();
    test_stall();
    test_force_release();
    test_reset_inflight();
    test_three();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
